bcd_conv_ctrl: RTL

//   Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") for the LCD

---
 rtl/bcd_conv_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the LCD number path.
// One binary bit is shifted into the BCD scratch register per cycle.
module bcd_conv_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               step;
    logic               last_step;

    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BIN_W-1:0]   shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add-3 correction; out-of-range nibbles collapse to 0 so the result stays defined.
    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd10)
                scratch_adj[4*i +: 4] = 4'd0;
            else if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            else
                scratch_adj[4*i +: 4] = scratch[4*i +: 4];
        end
    end

    assign shifted   = {scratch_adj, shift_reg} << 1;
    assign last_step = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch   <= '0;
            shift_reg <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
        end else if (load) begin
            scratch   <= '0;
            shift_reg <= bin_in;
            cnt       <= CNT_W'(BIN_W);
        end else if (step) begin
            scratch   <= shifted[BCD_W+BIN_W-1:BIN_W];
            shift_reg <= shifted[BIN_W-1:0];
            cnt       <= cnt - CNT_W'(1);
            if (last_step)
                bcd_out <= shifted[BCD_W+BIN_W-1:BIN_W];
        end
    end

endmodule
